mac_operand_sequencer: RTL

- Upstream feeder for the MAC datapath: holds one KSIZE x KSIZE kernel of 8-bit weights.
- Accepts a stream of 8-bit pixels under a valid/ready handshake and pairs each pixel with the matching kernel tap.
- Drives the MAC's operand inputs and enable, one pair per cycle.
- Marks window boundaries with first/last tap flags and counts completed windows.

---
 rtl/mac_operand_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mac_operand_sequencer.sv
// rtl/mac_operand_sequencer.sv - kernel weight store pairing streamed pixels with kernel taps for the MAC
module mac_operand_sequencer #(
    parameter int KSIZE = 3,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wt_load,
    input  logic          wt_valid,
    input  logic [DW-1:0] wt_data,
    input  logic          pix_valid,
    input  logic [DW-1:0] pix_data,
    output logic          pix_ready,
    output logic [DW-1:0] a_out,
    output logic [DW-1:0] b_out,
    output logic          mac_en,
    output logic          tap_first,
    output logic          tap_last,
    output logic          wt_loaded,
    output logic          busy,
    output logic [15:0]   win_count
);
    localparam int NTAP = KSIZE * KSIZE;
    localparam int TW   = $clog2(NTAP);
    localparam logic [TW-1:0] LAST_TAP = TW'(NTAP - 1);

    typedef enum logic [1:0] {IDLE, LOAD_W, RUN} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] widx_q, widx_d;
    logic [TW-1:0] tap_q, tap_d;
    logic [DW-1:0] weight_q [NTAP];
    logic [DW-1:0] a_q, b_q;
    logic          mac_en_q, first_q, last_q;
    logic [15:0]   win_q;
    logic          accept, wt_wr;
    logic [TW-1:0] wr_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (wt_load) state_d = LOAD_W;
            LOAD_W:  if (!wt_load && wt_valid && widx_q == LAST_TAP) state_d = RUN;
            RUN:     if (wt_load && tap_q == '0) state_d = LOAD_W;
            default: state_d = IDLE;
        endcase
    end

    // A reload request only takes effect between windows, so it also blocks the tap-0 pixel.
    always_comb begin
        pix_ready = 1'b0;
        wt_loaded = 1'b0;
        busy      = (tap_q != '0);
        case (state_q)
            LOAD_W:  busy = 1'b1;
            RUN: begin
                pix_ready = !(wt_load && tap_q == '0);
                wt_loaded = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        accept = pix_valid && pix_ready;
        wt_wr  = (state_q == LOAD_W) && wt_valid;
        wr_idx = wt_load ? '0 : widx_q;
        widx_d = '0;
        if (state_q == LOAD_W) begin
            if (wt_wr) begin
                widx_d = (wr_idx == LAST_TAP) ? '0 : wr_idx + TW'(1);
            end else if (!wt_load) begin
                widx_d = widx_q;
            end
        end
        tap_d = tap_q;
        if (accept) begin
            tap_d = (tap_q == LAST_TAP) ? '0 : tap_q + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            widx_q   <= '0;
            tap_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mac_en_q <= 1'b0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            win_q    <= '0;
            for (int i = 0; i < NTAP; i++) begin
                weight_q[i] <= '0;
            end
        end else begin
            widx_q   <= widx_d;
            tap_q    <= tap_d;
            mac_en_q <= accept;
            first_q  <= accept && (tap_q == '0);
            last_q   <= accept && (tap_q == LAST_TAP);
            if (accept) begin
                a_q <= pix_data;
                b_q <= weight_q[tap_q];
            end
            if (accept && tap_q == LAST_TAP) begin
                win_q <= win_q + 16'd1;
            end
            if (wt_wr) begin
                weight_q[wr_idx] <= wt_data;
            end
        end
    end

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign mac_en    = mac_en_q;
    assign tap_first = first_q;
    assign tap_last  = last_q;
    assign win_count = win_q;

endmodule
